// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative unsigned multiply/divide.
// Ports: clk/rst_n; in_valid/in_ready request; alu_op, a, b operands;
// out_valid pulse with result_lo/result_hi and carry/zero/ovf/dbz flags.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic             dbz_flag
);

  localparam int W = WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t state, state_d;

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2*W-1:0]   acc, acc_d;
  logic [W-1:0]     opnd, opnd_d;

  logic         vld_d;
  logic [W-1:0] lo_d, hi_d;
  logic         c_d, z_d, o_d, dbz_d;

  logic op_and, op_or, op_add, op_sub;
  logic op_slt, op_mul, op_div;

  assign op_and = (alu_op == 4'b0000);
  assign op_or  = (alu_op == 4'b0001);
  assign op_add = (alu_op == 4'b0010);
  assign op_sub = (alu_op == 4'b0110);
  assign op_slt = (alu_op == 4'b0111);
  assign op_mul = (alu_op == 4'b1000);
  assign op_div = (alu_op == 4'b1010);

  assign in_ready = (state == S_IDLE);

  // Single-cycle datapath
  logic [W:0] add_s, sub_s;
  logic       add_ov, sub_ov, slt;

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b}
               + {{W{1'b0}}, 1'b1};

  assign add_ov = (a[W-1] == b[W-1])
               && (add_s[W-1] != a[W-1]);
  assign sub_ov = (a[W-1] != b[W-1])
               && (sub_s[W-1] != a[W-1]);
  // Sign of a-b corrected by overflow gives a true signed compare.
  assign slt = sub_s[W-1] ^ sub_ov;

  logic [W-1:0] sc_lo, sc_hi;
  logic         sc_c, sc_o;

  always_comb begin
    sc_lo = '1;
    sc_hi = '0;
    sc_c  = 1'b0;
    sc_o  = 1'b0;
    unique case (1'b1)
      op_and: sc_lo = a & b;
      op_or:  sc_lo = a | b;
      op_add: begin
        sc_lo = add_s[W-1:0];
        sc_c  = add_s[W];
        sc_o  = add_ov;
      end
      op_sub: begin
        sc_lo = sub_s[W-1:0];
        sc_c  = sub_s[W];
        sc_o  = sub_ov;
      end
      op_slt: sc_lo = {{(W-1){1'b0}}, slt};
      // Only reached as a single-cycle op when b == 0.
      op_div: begin
        sc_lo = '1;
        sc_hi = a;
      end
      default: begin
        sc_lo = '1;
        sc_hi = '0;
      end
    endcase
  end

  // Shift-add multiply: acc = {partial, multiplier}.
  logic [W:0]   mul_sum;
  logic [2*W:0] mul_cat;
  logic [2*W-1:0] mul_nxt;

  assign mul_sum = {1'b0, acc[2*W-1:W]}
                 + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_cat = {mul_sum, acc[W-1:0]};
  assign mul_nxt = mul_cat[2*W:1];

  // Restoring divide: acc = {remainder, dividend/quotient}.
  logic [W:0]     rem_sh, div_diff;
  logic [2*W-1:0] div_nxt;

  assign rem_sh   = {acc[2*W-1:W], acc[W-1]};
  assign div_diff = rem_sh - {1'b0, opnd};
  assign div_nxt  = div_diff[W]
    ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
    : {div_diff[W-1:0], acc[W-2:0], 1'b1};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_d   = acc;
    opnd_d  = opnd;
    vld_d   = 1'b0;
    lo_d    = result_lo;
    hi_d    = result_hi;
    c_d     = carry_out;
    z_d     = zero_flag;
    o_d     = ovf_flag;
    dbz_d   = dbz_flag;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (op_mul) begin
            state_d = S_MUL;
            cnt_d   = '0;
            acc_d   = {{W{1'b0}}, b};
            opnd_d  = a;
          end else if (op_div && (b != '0)) begin
            state_d = S_DIV;
            cnt_d   = '0;
            acc_d   = {{W{1'b0}}, a};
            opnd_d  = b;
          end else begin
            vld_d = 1'b1;
            lo_d  = sc_lo;
            hi_d  = sc_hi;
            c_d   = sc_c;
            o_d   = sc_o;
            dbz_d = op_div;
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt + ONE;
        acc_d = mul_nxt;
        if (cnt == LAST) begin
          state_d = S_IDLE;
          vld_d   = 1'b1;
          lo_d    = mul_nxt[W-1:0];
          hi_d    = mul_nxt[2*W-1:W];
          c_d     = 1'b0;
          o_d     = 1'b0;
          dbz_d   = 1'b0;
        end
      end
      S_DIV: begin
        cnt_d = cnt + ONE;
        acc_d = div_nxt;
        if (cnt == LAST) begin
          state_d = S_IDLE;
          vld_d   = 1'b1;
          lo_d    = div_nxt[W-1:0];
          hi_d    = div_nxt[2*W-1:W];
          c_d     = 1'b0;
          o_d     = 1'b0;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Zero flag tracks the published result only.
    if (vld_d) begin
      z_d = (lo_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      out_valid <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      dbz_flag  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      acc       <= acc_d;
      opnd      <= opnd_d;
      out_valid <= vld_d;
      result_lo <= lo_d;
      result_hi <= hi_d;
      carry_out <= c_d;
      zero_flag <= z_d;
      ovf_flag  <= o_d;
      dbz_flag  <= dbz_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed and random checks of alu_mdu
// against an arithmetic reference model.
module tb_alu_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic [W-1:0] result_lo, result_hi;
  logic         carry_out, zero_flag;
  logic         ovf_flag, dbz_flag;

  int compared = 0;
  int mismatched = 0;

  alu_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .a(a), .b(b),
    .out_valid(out_valid),
    .result_lo(result_lo), .result_hi(result_hi),
    .carry_out(carry_out), .zero_flag(zero_flag),
    .ovf_flag(ovf_flag), .dbz_flag(dbz_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic c, z, o, d;
    int lat;
  } exp_t;

  task automatic chk(input string tag, input string fld,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s.%s: observed %0h expected %0h",
             tag, fld, obs, exp);
    end
  endtask

  function automatic logic ovf32(input longint r);
    logic [31:0] t;
    t = r[31:0];
    return r != longint'($signed(t));
  endfunction

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    longint sx, sy;
    logic [63:0] u;
    sx = $signed(x);
    sy = $signed(y);
    e.lo = '1; e.hi = '0;
    e.c = 0; e.o = 0; e.d = 0; e.lat = 0;
    case (op)
      4'h0: e.lo = x & y;
      4'h1: e.lo = x | y;
      4'h2: begin
        u = 64'(x) + 64'(y);
        e.lo = u[31:0];
        e.c = u[32];
        e.o = ovf32(sx + sy);
      end
      4'h6: begin
        e.lo = x - y;
        e.c = (x >= y);
        e.o = ovf32(sx - sy);
      end
      4'h7: e.lo = (sx < sy) ? 32'd1 : 32'd0;
      4'h8: begin
        u = 64'(x) * 64'(y);
        e.lo = u[31:0];
        e.hi = u[63:32];
        e.lat = 32;
      end
      4'hA: begin
        if (y == 0) begin
          e.lo = '1;
          e.hi = x;
          e.d = 1;
        end else begin
          e.lo = x / y;
          e.hi = x % y;
          e.lat = 32;
        end
      end
      default: begin
        e.lo = '1;
        e.hi = '0;
      end
    endcase
    e.z = (e.lo == 0);
    return e;
  endfunction

  task automatic check_res(input string tag, input exp_t e);
    chk(tag, "lo", result_lo, e.lo);
    chk(tag, "hi", result_hi, e.hi);
    chk(tag, "flags",
        {carry_out, zero_flag, ovf_flag, dbz_flag},
        {e.c, e.z, e.o, e.d});
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y);
    exp_t e;
    int n;
    logic busy_rdy;
    e = model(op, x, y);
    @(negedge clk);
    in_valid = 1'b1;
    alu_op = op;
    a = x;
    b = y;
    chk(tag, "rdy", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    busy_rdy = 1'b0;
    while (!out_valid && n < 40) begin
      busy_rdy = busy_rdy | in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, "lat", n, e.lat);
    chk(tag, "busy_rdy", busy_rdy, 0);
    check_res(tag, e);
    @(posedge clk);
    #1;
    chk(tag, "pulse", out_valid, 0);
    chk(tag, "hold", result_lo, e.lo);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] c [5];
    c = '{32'h0, 32'h1, 32'h7FFFFFFF,
          32'h80000000, 32'hFFFFFFFF};
    if ($urandom_range(0, 3) == 0)
      return c[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int n;
    logic seen;
    logic [3:0] ops [10];
    logic [W-1:0] qa [$];
    logic [W-1:0] qb [$];
    logic [W-1:0] x, y, pa, pb;

    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7,
            4'h8, 4'hA, 4'h3, 4'h9, 4'hF};

    #12;
    chk("rst", "ovld", out_valid, 0);
    chk("rst", "lo", result_lo, 0);
    chk("rst", "hi", result_hi, 0);
    chk("rst", "flags",
        {carry_out, zero_flag, ovf_flag, dbz_flag}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst", "rdy", in_ready, 1);

    run_op("add_wrap", 4'h2, 32'hFFFFFFFF, 32'h1);
    run_op("add_ovf", 4'h2, 32'h7FFFFFFF, 32'h1);
    run_op("sub", 4'h6, 32'd5, 32'd7);
    run_op("slt_neg", 4'h7, 32'hFFFFFFFF, 32'h1);
    run_op("slt_ovf", 4'h7, 32'h80000000, 32'h1);
    run_op("and", 4'h0, 32'hF0F0A5A5, 32'h0FF0FFFF);
    run_op("or", 4'h1, 32'h12340000, 32'h00005678);
    run_op("illegal", 4'h5, 32'h1234, 32'h5678);
    run_op("mulu_max", 4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("divu", 4'hA, 32'd100, 32'd7);
    run_op("divu_dbz", 4'hA, 32'd9, 32'd0);

    // Back-to-back ADDs with in_valid held high.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = model(4'h2, qa[0], qb[0]);
        void'(qa.pop_front());
        void'(qb.pop_front());
        chk("b2b", "ovld", out_valid, 1);
        check_res("b2b", e);
      end
      x = pick();
      y = pick();
      qa.push_back(x);
      qb.push_back(y);
      in_valid = 1'b1;
      alu_op = 4'h2;
      a = x;
      b = y;
    end
    @(negedge clk);
    in_valid = 1'b0;
    e = model(4'h2, qa[0], qb[0]);
    void'(qa.pop_front());
    void'(qb.pop_front());
    chk("b2b", "ovld", out_valid, 1);
    check_res("b2b", e);

    // ADD request held during DIVU; taken on return to IDLE.
    @(negedge clk);
    in_valid = 1'b1;
    alu_op = 4'hA;
    a = 32'd1000;
    b = 32'd33;
    @(posedge clk);
    #1;
    pa = 32'h11111111;
    pb = 32'h22222222;
    alu_op = 4'h2;
    a = pa;
    b = pb;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_div", "lat", n, 32);
    check_res("hold_div", model(4'hA, 32'd1000, 32'd33));
    chk("hold_div", "rdy", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("hold_add", "ovld", out_valid, 1);
    check_res("hold_add", model(4'h2, pa, pb));
    @(posedge clk);
    #1;
    chk("hold_add", "pulse", out_valid, 0);

    // Reset during a multiply.
    @(negedge clk);
    in_valid = 1'b1;
    alu_op = 4'h8;
    a = 32'hDEADBEEF;
    b = 32'h12345678;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", "ovld", out_valid, 0);
    chk("mid_rst", "lo", result_lo, 0);
    chk("mid_rst", "hi", result_hi, 0);
    chk("mid_rst", "flags",
        {carry_out, zero_flag, ovf_flag, dbz_flag}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst", "rdy", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("mid_rst", "no_ovld", seen, 0);
    chk("mid_rst", "hold_lo", result_lo, 0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      x = pick();
      y = pick();
      alu_op = ops[$urandom_range(0, 9)];
      if (alu_op == 4'hA && $urandom_range(0, 4) == 0)
        y = '0;
      run_op("rand", alu_op, x, y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width (>=4, even).
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept; accept = in_valid & in_ready at rising edge.
REQ-007 alu_op  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 MULU, 1010 DIVU; all other codes illegal.
REQ-008 a, b  input  WIDTH  operands, sampled only on accept.
REQ-009 out_valid  output  1  one-cycle pulse; result and flags valid.
REQ-010 result_lo  output  WIDTH  ALU result / product low / quotient.
REQ-011 result_hi  output  WIDTH  product high / remainder; 0 for single-cycle ops.
REQ-012 carry_out, zero_flag, ovf_flag, dbz_flag  output  1 each  carry, result_lo==0, signed overflow, divide-by-zero.

Function
REQ-013 States: IDLE, MUL, DIV; in_ready SHALL be 1 only in IDLE.
REQ-014 Single-cycle ops (AND/OR/ADD/SUB/SLT/illegal) SHALL be computed and registered at the accepting edge; out_valid high the following cycle; state stays IDLE, so back-to-back accepts give out_valid every cycle.
REQ-015 ADD: result_lo = (a+b) mod 2**WIDTH, carry_out = bit WIDTH of the sum.
REQ-016 SUB: computed as a + ~b + 1; carry_out = bit WIDTH (1 = no borrow).
REQ-017 ovf_flag SHALL be the signed overflow for ADD/SUB, 0 for all other ops.
REQ-018 SLT: result_lo = 1 if $signed(a) < $signed(b) else 0; must be correct even when a-b overflows.
REQ-019 AND/OR/SLT/MULU/DIVU SHALL drive carry_out = 0.
REQ-020 Illegal op: result_lo = all ones, result_hi = 0, all flags 0, single-cycle timing.
REQ-021 MULU: accepting edge loads operands, clears accumulator, counter = 0, goes to MUL; each subsequent edge performs one unsigned shift-add step.
REQ-022 MULU result: {result_hi,result_lo} = a*b (2*WIDTH bits, unsigned); registered at the WIDTH-th step edge with out_valid set; return to IDLE at the same edge.
REQ-023 DIVU: restoring division, one quotient bit per edge, same timing as MULU; result_lo = a/b, result_hi = a%b (unsigned).
REQ-024 DIVU with b==0: no iteration; single-cycle timing, result_lo = all ones, result_hi = a, dbz_flag = 1.
REQ-025 dbz_flag SHALL be 0 for every other operation.
REQ-026 zero_flag SHALL reflect result_lo only, for all ops, and be valid whenever out_valid = 1.
REQ-027 in_valid in MUL/DIV SHALL be ignored; operands never re-sampled mid-iteration.
REQ-028 Outputs (result, flags) SHALL hold their last values between out_valid pulses.
REQ-029 No backpressure on outputs; the consumer must capture results on out_valid.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, counter 0, result_lo/result_hi 0, all flags 0, out_valid 0; in_ready 1 once rst_n is high.
REQ-031 Reset mid-MUL/DIV SHALL abort the operation; no out_valid follows for it.

Verification (WIDTH=32)
REQ-032 ADD a=0xFFFFFFFF, b=1 -> result_lo 0, carry 1, zero 1, ovf 0, out_valid one cycle after accept; ADD 0x7FFFFFFF+1 -> 0x80000000, ovf 1.
REQ-033 SUB 5-7 -> 0xFFFFFFFE, carry 0; SLT a=0xFFFFFFFF, b=1 -> 1; SLT a=0x80000000, b=1 -> 1 (overflow case).
REQ-034 MULU 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001; out_valid exactly 32 edges after the accepting edge; in_ready 0 throughout.
REQ-035 DIVU 100/7 -> lo 14, hi 2, 32-step latency; DIVU 9/0 -> lo 0xFFFFFFFF, hi 9, dbz 1, single-cycle.
REQ-036 Assert rst_n low at step 10 of a MULU -> outputs 0 immediately, in_ready 1 after release, no out_valid pulse.
REQ-037 Hold in_valid with ADD every cycle -> out_valid each cycle, correct results; hold in_valid during DIVU -> the held request is accepted only on return to IDLE.
